// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the packet-level stream arbiter.
// Build option: STREAM_ARB_PRIO_EN gives source 0 strict priority.
package stream_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  localparam int PKT_CNT_W = 16;

  function automatic int grant_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_arbiter_rr_picker.sv
// Combinational round-robin picker starting after the last grantee.
// STREAM_ARB_PRIO_EN: source 0 wins outright, rotation covers 1..N-1.
module rr_picker
  import stream_arb_pkg::*;
#(
  parameter  int N_SRC   = 2,
  localparam int GRANT_W = grant_width(N_SRC)
) (
  input  logic [N_SRC-1:0]   i_req,
  input  logic [GRANT_W-1:0] i_last,
  output logic               o_any,
  output logic [GRANT_W-1:0] o_grant
);

  always_comb begin
    logic [GRANT_W-1:0] w_idx;
    logic               w_found;
    o_any   = |i_req;
    o_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= N_SRC; k++) begin
      w_idx = GRANT_W'((int'(i_last) + k) % N_SRC);
`ifdef STREAM_ARB_PRIO_EN
      if (!w_found && (w_idx != '0) && i_req[w_idx]) begin
`else
      if (!w_found && i_req[w_idx]) begin
`endif
        o_grant = w_idx;
        w_found = 1'b1;
      end
    end
`ifdef STREAM_ARB_PRIO_EN
    if (i_req[0]) o_grant = '0;
`endif
  end

endmodule

// File: rtl/stream_arbiter.sv
// Packet-atomic round-robin arbiter for byte streams with idle gap.
// Build option: STREAM_ARB_PRIO_EN (strict priority for source 0).
module stream_arbiter
  import stream_arb_pkg::*;
#(
  parameter  int N_SRC      = 2,
  parameter  int GAP_CYCLES = 12,
  localparam int GRANT_W    = grant_width(N_SRC)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SRC-1:0]     s_tvalid,
  input  logic [N_SRC-1:0]     s_tlast,
  input  logic [8*N_SRC-1:0]   s_tdata,
  output logic [N_SRC-1:0]     s_tready,
  output logic                 m_tvalid,
  output logic                 m_tlast,
  output logic [7:0]           m_tdata,
  input  logic                 m_tready,
  output logic [GRANT_W-1:0]   grant_id,
  output logic                 busy,
  output logic [PKT_CNT_W-1:0] pkt_count
);

  localparam int GAP_W =
    (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [GRANT_W-1:0] LAST_RST =
    GRANT_W'(N_SRC - 1);

  arb_state_t           r_state;
  logic [GRANT_W-1:0]   r_last_grant;
  logic [GRANT_W-1:0]   r_grant_id;
  logic [PKT_CNT_W-1:0] r_pkt_count;
  logic [GAP_W-1:0]     r_gap_cnt;

  logic                 w_any;
  logic [GRANT_W-1:0]   w_pick;
  logic                 w_eop;

  rr_picker #(
    .N_SRC (N_SRC)
  ) u_picker (
    .i_req   (s_tvalid),
    .i_last  (r_last_grant),
    .o_any   (w_any),
    .o_grant (w_pick)
  );

  // Ready depends only on state, grant and m_tready: sources may
  // build tlast from tready without forming a loop.
  always_comb begin
    s_tready = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tdata  = 8'h00;
    if (r_state == BUSY) begin
      s_tready[r_grant_id] = m_tready;
      m_tvalid = s_tvalid[r_grant_id];
      m_tlast  = s_tlast[r_grant_id] & s_tvalid[r_grant_id];
      m_tdata  = s_tdata[int'(r_grant_id)*8 +: 8];
    end
  end

  assign w_eop = (r_state == BUSY) & m_tvalid & m_tready & m_tlast;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= LAST_RST;
      r_grant_id   <= LAST_RST;
      r_pkt_count  <= '0;
      r_gap_cnt    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant_id <= w_pick;
`ifdef STREAM_ARB_PRIO_EN
            if (w_pick != '0) r_last_grant <= w_pick;
`else
            r_last_grant <= w_pick;
`endif
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (w_eop) begin
            r_pkt_count <= r_pkt_count + 1'b1;
            if (GAP_CYCLES == 0) begin
              r_state <= IDLE;
            end else begin
              r_gap_cnt <= GAP_W'(GAP_CYCLES);
              r_state   <= GAP;
            end
          end
        end
        GAP: begin
          r_gap_cnt <= r_gap_cnt - 1'b1;
          if (r_gap_cnt == GAP_W'(1)) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant_id  = r_grant_id;
  assign busy      = (r_state != IDLE);
  assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_stream_arbiter.sv
// Directed bench for stream_arbiter: a gapped instance (GAP=3) and
// a gapless instance (GAP=0), both with two sources.
module tb_stream_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  a_valid, a_last, a_sready;
  logic [15:0] a_data;
  logic        a_mvalid, a_mlast, a_mready, a_busy;
  logic [7:0]  a_mdata;
  logic [0:0]  a_gid;
  logic [15:0] a_pkt;

  logic [1:0]  b_valid, b_last, b_sready;
  logic [15:0] b_data;
  logic        b_mvalid, b_mlast, b_mready, b_busy;
  logic [7:0]  b_mdata;
  logic [0:0]  b_gid;
  logic [15:0] b_pkt;

  stream_arbiter #(.N_SRC(2), .GAP_CYCLES(3)) u_a (
    .clk(clk), .reset(reset),
    .s_tvalid(a_valid), .s_tlast(a_last), .s_tdata(a_data),
    .s_tready(a_sready),
    .m_tvalid(a_mvalid), .m_tlast(a_mlast), .m_tdata(a_mdata),
    .m_tready(a_mready),
    .grant_id(a_gid), .busy(a_busy), .pkt_count(a_pkt)
  );

  stream_arbiter #(.N_SRC(2), .GAP_CYCLES(0)) u_b (
    .clk(clk), .reset(reset),
    .s_tvalid(b_valid), .s_tlast(b_last), .s_tdata(b_data),
    .s_tready(b_sready),
    .m_tvalid(b_mvalid), .m_tlast(b_mlast), .m_tdata(b_mdata),
    .m_tready(b_mready),
    .grant_id(b_gid), .busy(b_busy), .pkt_count(b_pkt)
  );

  int n_pass = 0;
  int n_chk  = 0;

  logic [7:0] hello [13] = '{8'h00, 8'h0B, "H", "E", "L", "L",
                             "O", " ", "W", "O", "R", "L", "D"};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int cnt [2];
    int p, beat, cyc, got, c0, bc;
    bit done;
    a_valid = '0; a_last = '0; a_data = '0; a_mready = 1'b1;
    b_valid = '0; b_last = '0; b_data = '0; b_mready = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", a_busy, 0);
    chk("rst_gid", a_gid, 1);
    chk("rst_pkt", a_pkt, 0);
    chk("rst_out", {a_mvalid, a_mlast, a_mdata, a_sready}, 0);
    chk("rst_b_pkt", b_pkt, 0);
    reset = 1'b0;

    // single 13-byte packet from source 0, then gap
    a_valid[0] = 1'b1;
    a_data[7:0] = hello[0];
    #1;
    chk("t1_idle", {a_mvalid, a_sready}, 0);
    tick();
    for (int i = 0; i < 13; i++) begin
      a_data[7:0] = hello[i];
      a_last[0] = (i == 12);
      #1;
      chk("t1_beat", {a_mvalid, a_mlast, a_mdata, a_sready, a_gid},
          {1'b1, 1'(i == 12), hello[i], 2'b01, 1'b0});
      tick();
    end
    a_valid = '0; a_last = '0; a_data = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t1_gap", {a_busy, a_mvalid, a_mdata, a_sready, a_pkt},
          {1'b1, 1'b0, 8'h00, 2'b00, 16'd1});
      tick();
    end
    chk("t1_idle_after", a_busy, 0);

    // both sources requesting continuously, 4-byte packets
    do_reset();
    cnt = '{0, 0};
    p = 0; beat = 0; cyc = 0;
    while (p < 4 && cyc < 80) begin
      a_valid = 2'b11;
      for (int s = 0; s < 2; s++) begin
        a_data[8*s +: 8] = {4'(s), 4'(cnt[s] % 4)};
        a_last[s] = (cnt[s] % 4 == 3);
      end
      #1;
      if (a_mvalid && a_mready) begin
        if (beat == 0) chk("t2_gid", a_gid, p % 2);
        chk("t2_byte", {a_mlast, a_mdata},
            {1'(beat == 3), 4'(p % 2), 4'(beat)});
        beat++;
        if (a_mlast) begin
          p++;
          beat = 0;
        end
      end
      for (int s = 0; s < 2; s++)
        if (a_sready[s] && a_valid[s]) cnt[s]++;
      tick();
      cyc++;
    end
    chk("t2_done", p, 4);
    chk("t2_pkt", a_pkt, 4);
    a_valid = '0; a_last = '0;
    repeat (4) tick();

    // source 0 under toggling m_tready while source 1 waits
    got = 0; c0 = 0; cyc = 0; done = 1'b0;
    a_valid = 2'b11;
    while (!done && cyc < 40) begin
      a_data[7:0]  = 8'hA0 + 8'(c0);
      a_last[0]    = (c0 == 5);
      a_data[15:8] = 8'h55;
      a_last[1]    = 1'b0;
      #1;
      if (a_busy) begin
        chk("t3_sready", a_sready, {1'b0, a_mready});
        chk("t3_out", {a_mvalid, a_mlast, a_mdata},
            {1'b1, 1'(got == 5), 8'hA0 + 8'(got)});
        if (a_mready) begin
          got++;
          if (a_mlast) done = 1'b1;
        end
      end
      if (a_sready[0]) c0++;
      tick();
      a_mready = ~a_mready;
      cyc++;
    end
    a_valid = '0; a_last = '0; a_mready = 1'b1;
    chk("t3_cnt", got, 6);
    chk("t3_pkt", a_pkt, 5);
    repeat (4) tick();

    // asynchronous reset in the middle of a packet
    a_valid = 2'b01;
    a_data[7:0] = hello[0];
    tick();
    for (int i = 0; i < 5; i++) begin
      a_data[7:0] = hello[i];
      tick();
    end
    a_data[7:0] = hello[5];
    #1;
    chk("t4_pre", {a_mvalid, a_sready, a_pkt}, {1'b1, 2'b01, 16'd5});
    reset = 1'b1;
    #1;
    chk("t4_rst", {a_mvalid, a_sready, a_busy, a_pkt, a_gid},
        {1'b0, 2'b00, 1'b0, 16'd0, 1'b1});
    @(posedge clk);
    #1;
    reset = 1'b0;
    a_valid = 2'b11;
    #1;
    chk("t4_idle", a_busy, 0);
    tick();
    chk("t4_regrant", {a_busy, a_gid}, {1'b1, 1'b0});
    a_valid = '0;

    // gapless instance: one idle cycle between back-to-back packets
    bc = 0;
    b_valid[0] = 1'b1;
    for (int c = 0; c < 9; c++) begin
      b_data[7:0] = 8'(bc);
      b_last[0] = (bc % 2 == 1);
      #1;
      chk("t5_cyc", {b_busy, b_mvalid, b_mlast},
          (c % 3 == 0) ? 3'b000 : (c % 3 == 1) ? 3'b110 : 3'b111);
      if (b_sready[0]) bc++;
      tick();
    end
    chk("t5_pkt", b_pkt, 3);
    b_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stream_arbiter.md
Name: stream_arbiter

Overview:
- Packet-level round-robin arbiter that shares one byte-wide valid/ready/last TX stream (MAC transmit input) between N_SRC byte-stream sources such as message generators.
- Grants whole packets only: once a source is granted, it owns the output until its last byte handshakes.
- Inserts a programmable idle gap between packets.
- Reports the active grant and a running packet count.

Parameters:
- N_SRC, 2, number of sources (2..8).
- GAP_CYCLES, 12, idle cycles forced after each packet's last beat (0 = no gap).
- GRANT_W, $clog2(N_SRC) (min 1), width of grant_id; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_tvalid  in  N_SRC  per-source valid.
- s_tlast  in  N_SRC  per-source last-byte flag.
- s_tdata  in  8*N_SRC  per-source byte; source i occupies [8*i+7:8*i].
- s_tready  out  N_SRC  per-source ready.
- m_tvalid  out  1  output valid.
- m_tlast  out  1  output last.
- m_tdata  out  8  output byte.
- m_tready  in  1  downstream ready.
- grant_id  out  GRANT_W  index of the current or most recent grantee.
- busy  out  1  high in BUSY or GAP.
- pkt_count  out  16  packets completed since reset; wraps 0xFFFF -> 0.

Behaviour:
- States: IDLE, BUSY, GAP. Reset values:
  - state = IDLE
  - last_grant = N_SRC-1, so the first pick is source 0
  - grant_id = N_SRC-1
  - pkt_count = 0, gap_cnt = 0
  - All handshake outputs low.
- Asynchronous reset takes effect immediately, including mid-packet. s_tready and m_tvalid drop in the same instant; the interrupted packet is abandoned, not resumed.
- IDLE:
  - If any s_tvalid is high, select the first requester scanning last_grant+1, last_grant+2, ... modulo N_SRC.
  - Register the selection into grant_id and last_grant; go to BUSY next cycle.
  - One cycle of arbitration latency; no outputs asserted in IDLE.
  - A source whose s_tvalid drops before the grant registers is still granted.
- BUSY, zero-latency combinational passthrough from the granted source g:
  - m_tvalid = s_tvalid[g]
  - m_tdata = s_tdata[g]
  - m_tlast = s_tlast[g] & s_tvalid[g]
  - s_tready[g] = m_tready; all other s_tready = 0.
  - s_tready must not depend combinationally on s_tlast or s_tvalid, because sources may derive tlast from tready.
  - If the source drops s_tvalid mid-packet, m_tvalid follows it low and the grant is held. No timeout.
- End of packet: a beat with m_tvalid & m_tready & m_tlast.
  - pkt_count increments.
  - If GAP_CYCLES == 0, go to IDLE next cycle.
  - Otherwise load gap_cnt = GAP_CYCLES and go to GAP.
- GAP:
  - All s_tready = 0 and m_tvalid = 0.
  - gap_cnt decrements each cycle; leave for IDLE on the cycle gap_cnt == 1.
  - Exactly GAP_CYCLES cycles are spent in GAP.
- Fairness: with all sources requesting continuously, grants rotate 0,1,...,N_SRC-1,0.
- A lone requester is re-granted after each gap.
- Simultaneous requests in IDLE are resolved purely by the rotation pointer.
- m_tdata is 8'h00 whenever not BUSY.

Optional Feature:
- Macro: STREAM_ARB_PRIO_EN.
- Defined: source 0 has strict priority. In IDLE, if s_tvalid[0] is high, grant source 0 regardless of the rotation pointer; otherwise round-robin among sources 1..N_SRC-1. last_grant is updated only by non-zero grants.
- Not defined: pure round-robin as above.
- Packet atomicity and gap insertion are identical in both builds.

Decomposition:
- Package stream_arb_pkg holds:
  - the state enum typedef (IDLE, BUSY, GAP)
  - localparam PKT_CNT_W = 16
  - function grant_width(n), returning max(1, $clog2(n)).
- Natural sub-module: rr_picker.
  - Purely combinational.
  - Inputs: request vector and last_grant.
  - Outputs: any_req and next grant index; honours STREAM_ARB_PRIO_EN.
  - Unit-testable in isolation.

Test Plan:
- N_SRC=2, GAP_CYCLES=3, m_tready=1. Source 0 sends 13 bytes (0x00,0x0B,"HELLO WORLD") -> m_tdata matches byte-for-byte, m_tlast on byte 13, pkt_count=1, exactly 3 GAP cycles with m_tvalid=0, then IDLE.
- Both sources request continuously, 4-byte packets -> grant_id sequence 0,1,0,1; no interleaving of bytes within a packet; pkt_count=4 after four packets.
- Source 0 mid-packet, m_tready toggles 1,0,1,0 -> data held stable while m_tready=0; s_tready[1] stays 0 throughout; no bytes lost or duplicated.
- Assert reset for 1 cycle after byte 5 of a 13-byte packet -> outputs low immediately; state IDLE, pkt_count=0; next grant is source 0.
- GAP_CYCLES=0, single source sending back-to-back -> exactly one IDLE cycle between last beat and next first beat.
- STREAM_ARB_PRIO_EN defined, N_SRC=3, all requesting continuously -> grants 0,0,0,... and sources 1,2 never served; drop s_tvalid[0] -> grants alternate 1,2.
